// File: rtl/lcd_bus_monitor_if.sv
// 4-bit HD44780 bus between an LCD driver (master) and the bus monitor (slave).
interface lcd_bus_monitor_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [3:0] lcd_d;

   modport master (output lcd_e, lcd_rs, lcd_rw, lcd_d);
   modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_d);
endinterface

// File: rtl/lcd_bus_monitor.sv
// Responder-side model of a 4-bit HD44780 bus: reassembles nibbles, decodes the
// instruction subset, and keeps a 2x16 shadow of the visible display.
module lcd_bus_monitor #(
   parameter int CMD_BUSY_CYCLES   = 2000,
   parameter int CLEAR_BUSY_CYCLES = 82000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   lcd_bus_monitor_if.slave i_bus,
   output logic [127:0]     o_row_a,
   output logic [127:0]     o_row_b,
   output logic             o_byte_valid,
   output logic [7:0]       o_byte_data,
   output logic             o_byte_rs,
   output logic             o_mode4,
   output logic [6:0]       o_ddram_addr,
   output logic             o_timing_err,
   output logic             o_proto_err
);
   localparam int MAX_BUSY = (CLEAR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : CMD_BUSY_CYCLES;
   localparam int BW       = $clog2(MAX_BUSY + 1);

   typedef enum logic [1:0] {M8, M4_HI, M4_LO} mode_t;

   logic          r_e_s1, r_e_s2, r_e_s3;
   logic [5:0]    r_ctl_s1, r_ctl_s2;
   mode_t         r_mode;
   logic [3:0]    r_hi;
   logic          r_hi_rs;
   logic          r_dir_inc;
   logic [BW-1:0] r_busy;
   logic [127:0]  r_row_a, r_row_b;
   logic [6:0]    r_addr;
   logic          r_mode4, r_byte_valid, r_byte_rs, r_timing_err, r_proto_err;
   logic [7:0]    r_byte_data;

   logic          w_strobe, w_rs, w_rw, w_exec, w_chk, w_brs, w_long;
   logic [3:0]    w_d, w_col;
   logic [7:0]    w_byte;

   // RS/RW/D ride the same synchronizer depth as E so they line up with the strobe
   assign w_strobe = r_e_s3 & ~r_e_s2;
   assign w_rs     = r_ctl_s2[5];
   assign w_rw     = r_ctl_s2[4];
   assign w_d      = r_ctl_s2[3:0];

   assign w_chk  = w_strobe & ~w_rw & ((r_mode == M8) | (r_mode == M4_LO));
   assign w_exec = w_strobe & ~w_rw & (((r_mode == M8) & ~w_rs) | (r_mode == M4_LO));
   assign w_byte = (r_mode == M8) ? {w_d, 4'h0} : {r_hi, w_d};
   assign w_brs  = (r_mode == M8) ? 1'b0 : r_hi_rs;
   assign w_long = ~w_brs & (w_byte[7:2] == 6'd0) & (w_byte[1:0] != 2'd0);
   assign w_col  = 4'd15 - r_addr[3:0];

   function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
      if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_e_s1       <= 1'b0;
         r_e_s2       <= 1'b0;
         r_e_s3       <= 1'b0;
         r_ctl_s1     <= '0;
         r_ctl_s2     <= '0;
         r_mode       <= M8;
         r_hi         <= '0;
         r_hi_rs      <= 1'b0;
         r_dir_inc    <= 1'b1;
         r_busy       <= '0;
         r_row_a      <= {16{8'h20}};
         r_row_b      <= {16{8'h20}};
         r_addr       <= '0;
         r_mode4      <= 1'b0;
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
         r_byte_rs    <= 1'b0;
         r_timing_err <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         r_e_s1       <= i_bus.lcd_e;
         r_e_s2       <= r_e_s1;
         r_e_s3       <= r_e_s2;
         r_ctl_s1     <= {i_bus.lcd_rs, i_bus.lcd_rw, i_bus.lcd_d};
         r_ctl_s2     <= r_ctl_s1;
         r_byte_valid <= 1'b0;
         r_proto_err  <= 1'b0;
         r_timing_err <= w_chk && (r_busy != '0);

         if (w_strobe) begin
            if (w_rw) r_proto_err <= 1'b1;
            else begin
               case (r_mode)
                  M8:      if (w_rs) r_proto_err <= 1'b1;
                  M4_HI:   begin r_hi <= w_d; r_hi_rs <= w_rs; r_mode <= M4_LO; end
                  M4_LO:   begin r_mode <= M4_HI; if (w_rs != r_hi_rs) r_proto_err <= 1'b1; end
                  default: r_mode <= M8;
               endcase
            end
         end

         if (w_exec)           r_busy <= w_long ? BW'(CLEAR_BUSY_CYCLES) : BW'(CMD_BUSY_CYCLES);
         else if (r_busy != '0) r_busy <= r_busy - BW'(1);

         if (w_exec) begin
            r_byte_valid <= 1'b1;
            r_byte_data  <= w_byte;
            r_byte_rs    <= w_brs;
            if (w_brs) begin
               if (r_addr[6:4] == 3'b000) r_row_a[{w_col, 3'b000} +: 8] <= w_byte;
               if (r_addr[6:4] == 3'b100) r_row_b[{w_col, 3'b000} +: 8] <= w_byte;
               r_addr <= f_step(r_addr, r_dir_inc);
            end else begin
               casez (w_byte)
                  8'b1???????: r_addr <= w_byte[6:0];
                  8'b001?????: if (r_mode == M8 && !w_byte[4]) begin
                                  r_mode  <= M4_HI;
                                  r_mode4 <= 1'b1;
                               end
                  8'b000001??: r_dir_inc <= w_byte[1];
                  8'b0000001?: r_addr <= '0;
                  8'b00000001: begin
                                  r_row_a   <= {16{8'h20}};
                                  r_row_b   <= {16{8'h20}};
                                  r_addr    <= '0;
                                  r_dir_inc <= 1'b1;
                               end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_row_a      = r_row_a;
   assign o_row_b      = r_row_b;
   assign o_byte_valid = r_byte_valid;
   assign o_byte_data  = r_byte_data;
   assign o_byte_rs    = r_byte_rs;
   assign o_mode4      = r_mode4;
   assign o_ddram_addr = r_addr;
   assign o_timing_err = r_timing_err;
   assign o_proto_err  = r_proto_err;
endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Responder-side model of the 4-bit HD44780 character-LCD bus driven by LCD_module.
- Samples LCD_E/RS/RW/D, reassembles nibble pairs into bytes, and decodes the instruction subset LCD_module issues.
- Maintains a 2x16 shadow of the display as row_a/row_b, in the same 128-bit packing the top levels feed to LCD_module.
- Used on-chip for self-check and in benches as the scoreboard for any LCD-driving lab top.

Parameters:
CMD_BUSY_CYCLES, 2000, busy window after any non-clear/home instruction or data write (40 us at 50 MHz)
CLEAR_BUSY_CYCLES, 82000, busy window after clear or home (1.64 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
lcd_e  input  1  LCD enable strobe; data latched on falling edge
lcd_rs  input  1  0 = instruction, 1 = data
lcd_rw  input  1  0 = write, 1 = read
lcd_d  input  4  LCD data nibble (DB7..DB4)
row_a  output  128  line 1 shadow; char 0 in [127:120], char 15 in [7:0]
row_b  output  128  line 2 shadow, same packing
byte_valid  output  1  one-cycle pulse when a full byte is decoded
byte_data  output  8  last decoded byte, held until the next byte
byte_rs  output  1  RS of last decoded byte
mode4  output  1  1 once the interface has switched to 4-bit mode
ddram_addr  output  7  current address counter
timing_err  output  1  one-cycle pulse: strobe arrived while busy
proto_err  output  1  one-cycle pulse: read strobe, or data write while in 8-bit mode

Behaviour:
Reset (synchronous, active-high, overrides everything, mid-operation included):
- row_a and row_b = all 0x20.
- ddram_addr = 0, mode4 = 0, byte_valid = 0, byte_data = 0, byte_rs = 0.
- Error pulses = 0, busy counter = 0, nibble phase = HI, increment direction = +1.

Input capture:
- lcd_e, lcd_rs, lcd_rw and lcd_d pass through matched 2-FF synchronizers.
- A strobe is the synchronized E going 1 -> 0. RS/RW/D are taken from the same synchronized stage.
- byte_valid and the row/addr update are registered on the 3rd rising clk edge after the first edge that samples raw lcd_e low.

Mode state machine (M8, M4_HI, M4_LO):
- M8, strobe with RW=0, RS=0: byte = {D,4'h0} is executed as an instruction; byte_valid pulses.
  - If D == 4'h2: go to M4_HI and set mode4 = 1.
  - D == 4'h3 stays in M8.
- M8, strobe with RS=1: proto_err pulses; no other effect.
- M4_HI, strobe: latch the high nibble and RS, go to M4_LO. No byte_valid.
- M4_LO, strobe: byte = {hi,D}; execute; pulse byte_valid; go to M4_HI.
  - The byte uses the RS latched with the high nibble.
  - If RS differs between the two nibbles, proto_err pulses and the byte is still executed.
- Any strobe with RW=1: proto_err pulses; the strobe is ignored and the phase is unchanged.

Instruction decode (RS=0), highest set bit wins:
- 1xxxxxxx: ddram_addr = byte[6:0].
- 01xxxxxx: CGRAM address; ignored.
- 001xxxxx: function set. If DL=0 (byte[4]) while in M8, go to M4_HI.
- 0001xxxx: shift; ignored.
- 00001xxx: display control; ignored.
- 000001xx: entry mode. Direction = byte[1] ? +1 : -1.
- 0000001x: home. ddram_addr = 0; long busy.
- 00000001: clear. Both rows = 0x20, ddram_addr = 0, direction = +1; long busy.
- 00000000: no-op.

Data write (RS=1):
- Addresses 0x00-0x0F write row_a char[addr].
- Addresses 0x40-0x4F write row_b char[addr-0x40].
- Any other address (invisible) writes nothing.
- The address then steps by the direction. Wrap: +1 from 0x27 -> 0x40, +1 from 0x67 -> 0x00, -1 from 0x00 -> 0x67, -1 from 0x40 -> 0x27.
- Any address outside 0x00-0x27 and 0x40-0x67 steps as 7-bit modulo arithmetic.

Busy:
- Each executed byte loads the busy counter with CMD_BUSY_CYCLES, or CLEAR_BUSY_CYCLES for clear/home.
- The counter decrements to 0.
- A strobe while the counter is nonzero pulses timing_err, and the strobe is processed normally.
- Only a 4-bit low-nibble strobe or an M8 strobe is checked; high-nibble strobes are exempt.

Simultaneous events:
- Reset beats a strobe.
- A clear overwrites any pending row state in the same cycle.

Test Plan:
- Reset, then 8-bit strobes D=3,3,3,2 with RS=0 -> 4 byte_valid pulses (0x30,0x30,0x30,0x20); mode4 = 1 after the 4th; no errors.
- In 4-bit mode, send 0x01, then data 0x50 ('P') at 0x00 -> row_a[127:120] = 0x50, rest 0x20, ddram_addr = 0x01.
- Send 0xC0, then 16 data bytes 0x41..0x50 -> row_b = "ABCDEFGHIJKLMNOP", ddram_addr = 0x50; row_a unchanged.
- Set addr 0x27, write 0x58 -> addr = 0x40, no row change. Entry mode 0x04, set addr 0x40, write 0x59 -> row_b char0 = 'Y', addr = 0x27.
- Issue clear, then a strobe 100 cycles later with CLEAR_BUSY_CYCLES = 82000 -> timing_err pulse, byte still decoded. Same strobe at 82100 cycles -> no timing_err.
- Send a strobe with RW=1 -> proto_err pulse, phase unchanged. Then assert reset between nibbles -> next strobe is treated as M8; rows all 0x20; mode4 = 0.
